// File: rtl/image_mem_arbiter.sv
// image_mem_arbiter
//   Shares one image memory port between N_REQ line-walker read requesters
//   and a host write path. Host writes take priority; reads are granted
//   round-robin, fully pipelined, and return tagged responses in grant order.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req/req_addr/req_sel/req_half   per-requester read request + payload (packed)
//   gate                  1 = new grants allowed, 0 = drain in-flight reads
//   grant                 combinational one-hot grant
//   host_wr_*             host write request/payload, host_wr_ack pulse
//   mem_addr/which_mem/mem_rd/we/mem_wdata   registered memory port
//   mem_data              read data, valid RD_LAT cycles after mem_rd
//   rsp_val/rsp_id/rsp_data  registered read response
//   busy                  any read in flight or response being presented
module image_mem_arbiter #(
    parameter int N_REQ  = 40,
    parameter int RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*10-1:0]   req_addr,
    input  logic [N_REQ*10-1:0]   req_sel,
    input  logic [N_REQ-1:0]      req_half,
    input  logic                  gate,
    output logic [N_REQ-1:0]      grant,
    input  logic                  host_wr_val,
    input  logic [9:0]            host_wr_addr,
    input  logic [9:0]            host_wr_sel,
    input  logic [19:0]           host_wr_data,
    output logic                  host_wr_ack,
    output logic [9:0]            mem_addr,
    output logic [9:0]            which_mem,
    output logic                  mem_rd,
    output logic                  we,
    output logic [19:0]           mem_wdata,
    input  logic [19:0]           mem_data,
    output logic                  rsp_val,
    output logic [5:0]            rsp_id,
    output logic signed [8:0]     rsp_data,
    output logic                  busy
);

    logic [5:0]  last_grant;
    logic        eligible;
    logic        found_hi, found_lo, grant_any;
    logic [5:0]  idx_hi, idx_lo, grant_idx;
    logic [9:0]  sel_addr, sel_sel;
    logic        sel_half;

    // Tag pipeline: stage k is visible in cycle t+1+k for a grant in cycle t,
    // so stage RD_LAT lines up with mem_data for that read.
    logic [RD_LAT:0] vld_pipe;
    logic [5:0]      id_pipe   [RD_LAT+1];
    logic            half_pipe [RD_LAT+1];

    assign eligible = gate && !host_wr_val && !reset;

    // Round-robin: first requester strictly above last_grant wins; if none,
    // first requester at or below last_grant (the wrapped part of the search).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (eligible && req[i] && !found_hi && (6'(i) > last_grant)) begin
                found_hi = 1'b1;
                idx_hi   = 6'(i);
            end
            if (eligible && req[i] && !found_lo && (6'(i) <= last_grant)) begin
                found_lo = 1'b1;
                idx_lo   = 6'(i);
            end
        end
        grant_any = found_hi || found_lo;
        grant_idx = found_hi ? idx_hi : idx_lo;
    end

    always_comb begin
        grant    = '0;
        sel_addr = '0;
        sel_sel  = '0;
        sel_half = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_any && (grant_idx == 6'(i))) begin
                grant[i] = 1'b1;
                sel_addr = req_addr[i*10 +: 10];
                sel_sel  = req_sel[i*10 +: 10];
                sel_half = req_half[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant  <= 6'(N_REQ - 1);
            mem_rd      <= 1'b0;
            we          <= 1'b0;
            host_wr_ack <= 1'b0;
            mem_addr    <= '0;
            which_mem   <= '0;
            mem_wdata   <= '0;
            rsp_val     <= 1'b0;
            rsp_id      <= '0;
            rsp_data    <= '0;
            busy        <= 1'b0;
            vld_pipe    <= '0;
            for (int k = 0; k <= RD_LAT; k++) begin
                id_pipe[k]   <= '0;
                half_pipe[k] <= 1'b0;
            end
        end else begin
            // Memory port: a host write blocks grants, so at most one op.
            we          <= host_wr_val;
            host_wr_ack <= host_wr_val;
            mem_rd      <= grant_any;
            if (host_wr_val) begin
                mem_addr  <= host_wr_addr;
                which_mem <= host_wr_sel;
                mem_wdata <= host_wr_data;
            end else if (grant_any) begin
                mem_addr   <= sel_addr;
                which_mem  <= sel_sel;
                last_grant <= grant_idx;
            end

            vld_pipe[0]  <= grant_any;
            id_pipe[0]   <= grant_idx;
            half_pipe[0] <= sel_half;
            for (int k = 1; k <= RD_LAT; k++) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                id_pipe[k]   <= id_pipe[k-1];
                half_pipe[k] <= half_pipe[k-1];
            end

            rsp_val <= vld_pipe[RD_LAT];
            if (vld_pipe[RD_LAT]) begin
                rsp_id   <= id_pipe[RD_LAT];
                rsp_data <= half_pipe[RD_LAT] ? mem_data[8:0] : mem_data[17:9];
            end

            // Next-cycle view: a new grant or any tag still moving toward rsp_val.
            busy <= grant_any || (|vld_pipe);
        end
    end

endmodule

// File: tb/tb_image_mem_arbiter.sv
module tb_image_mem_arbiter;

    localparam int N = 40;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*10-1:0] req_addr;
    logic [N*10-1:0] req_sel;
    logic [N-1:0]    req_half;
    logic            gate;
    logic [N-1:0]    grant;
    logic            host_wr_val;
    logic [9:0]      host_wr_addr;
    logic [9:0]      host_wr_sel;
    logic [19:0]     host_wr_data;
    logic            host_wr_ack;
    logic [9:0]      mem_addr;
    logic [9:0]      which_mem;
    logic            mem_rd;
    logic            we;
    logic [19:0]     mem_wdata;
    logic [19:0]     mem_data;
    logic            rsp_val;
    logic [5:0]      rsp_id;
    logic [8:0]      rsp_data;
    logic            busy;

    image_mem_arbiter #(.N_REQ(N), .RD_LAT(2)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
        .req_sel(req_sel), .req_half(req_half), .gate(gate), .grant(grant),
        .host_wr_val(host_wr_val), .host_wr_addr(host_wr_addr),
        .host_wr_sel(host_wr_sel), .host_wr_data(host_wr_data),
        .host_wr_ack(host_wr_ack), .mem_addr(mem_addr), .which_mem(which_mem),
        .mem_rd(mem_rd), .we(we), .mem_wdata(mem_wdata), .mem_data(mem_data),
        .rsp_val(rsp_val), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-requester payload tables driven onto the packed inputs.
    logic [9:0] a_tab [N];
    logic [9:0] s_tab [N];
    logic       h_tab [N];
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_addr[i*10 +: 10] = a_tab[i];
            req_sel[i*10 +: 10]  = s_tab[i];
            req_half[i]          = h_tab[i];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected read pipeline: index 0 = mem_rd cycle, index 3 = rsp_val cycle.
    logic       e_v [4];
    int         e_id[4];
    logic       e_h [4];
    logic [19:0] md;

    // One clock cycle: drive inputs, check combinational grant, clock,
    // then check registered outputs against the expected pipeline.
    task automatic step(input logic [N-1:0] r, input logic g, input logic hw,
                        input int exp_id, input logic rst);
        logic [N-1:0] expg;
        logic [8:0]   expd;
        req = r; gate = g; host_wr_val = hw; reset = rst;
        #1;
        expg = '0;
        if (exp_id >= 0) expg[exp_id] = 1'b1;
        chk("grant", 64'(grant), 64'(expg));
        @(posedge clk); #1;
        if (rst) begin
            for (int k = 0; k < 4; k++) begin e_v[k] = 1'b0; e_id[k] = 0; e_h[k] = 1'b0; end
            chk("reset_outputs",
                64'({mem_rd, we, host_wr_ack, rsp_val, busy, mem_addr, which_mem, rsp_id, rsp_data}),
                64'(0) );
            chk("reset_wdata", 64'(mem_wdata), 64'(0));
        end else begin
            for (int k = 3; k > 0; k--) begin e_v[k] = e_v[k-1]; e_id[k] = e_id[k-1]; e_h[k] = e_h[k-1]; end
            e_v[0]  = (exp_id >= 0);
            e_id[0] = (exp_id >= 0) ? exp_id : 0;
            e_h[0]  = (exp_id >= 0) ? h_tab[exp_id] : 1'b0;
            chk("mem_rd", 64'(mem_rd), 64'(e_v[0]));
            chk("we", 64'(we), 64'(hw));
            chk("host_wr_ack", 64'(host_wr_ack), 64'(hw));
            if (hw) begin
                chk("wr_addr", 64'(mem_addr), 64'(host_wr_addr));
                chk("wr_sel", 64'(which_mem), 64'(host_wr_sel));
                chk("wr_data", 64'(mem_wdata), 64'(host_wr_data));
            end
            if (e_v[0]) begin
                chk("rd_addr", 64'(mem_addr), 64'(a_tab[e_id[0]]));
                chk("rd_sel", 64'(which_mem), 64'(s_tab[e_id[0]]));
            end
            chk("rsp_val", 64'(rsp_val), 64'(e_v[3]));
            if (e_v[3]) begin
                chk("rsp_id", 64'(rsp_id), 64'(e_id[3]));
                expd = e_h[3] ? md[8:0] : md[17:9];
                chk("rsp_data", 64'(rsp_data), 64'(expd));
            end
            chk("busy", 64'(busy), 64'(e_v[0] | e_v[1] | e_v[2] | e_v[3]));
        end
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         gate;
        logic         hw;
        int           exp;
    } vec_t;
    vec_t tab[$];

    function automatic logic [N-1:0] bits(input int a, input int b);
        logic [N-1:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        return v;
    endfunction

    function automatic vec_t mk(input logic [N-1:0] r, input logic g, input logic hw, input int e);
        vec_t v;
        v.req = r; v.gate = g; v.hw = hw; v.exp = e;
        return v;
    endfunction

    initial begin
        logic [N-1:0] ones;
        ones = '1;
        md = 20'h0A5C3;
        mem_data = md;
        host_wr_addr = 10'd100;
        host_wr_sel  = 10'd7;
        host_wr_data = 20'hABCDE;
        for (int i = 0; i < N; i++) begin
            a_tab[i] = 10'(i * 7 + 3);
            s_tab[i] = 10'(i + 100);
            h_tab[i] = 1'(i % 2);
        end
        req = '0; gate = 1'b0; host_wr_val = 1'b0; reset = 1'b1;

        // Table: sustained round-robin, gating, wrap, host priority.
        for (int i = 0; i < 45; i++) tab.push_back(mk(ones, 1'b1, 1'b0, i % 40));
        tab.push_back(mk(ones, 1'b0, 1'b0, -1));
        tab.push_back(mk(bits(39, -1), 1'b1, 1'b0, 39));
        tab.push_back(mk(bits(2, 39), 1'b1, 1'b0, 2));
        tab.push_back(mk(bits(2, 39), 1'b1, 1'b0, 39));
        tab.push_back(mk(bits(2, 39), 1'b1, 1'b0, 2));
        tab.push_back(mk(bits(3, 9), 1'b1, 1'b1, -1));
        tab.push_back(mk(bits(3, 9), 1'b1, 1'b0, 3));
        tab.push_back(mk(bits(3, 9), 1'b1, 1'b0, 9));
        tab.push_back(mk(bits(3, 9), 1'b1, 1'b1, -1));
        tab.push_back(mk(bits(3, 9), 1'b1, 1'b1, -1));
        tab.push_back(mk(bits(3, 9), 1'b1, 1'b0, 3));
        for (int i = 0; i < 5; i++) tab.push_back(mk('0, 1'b1, 1'b0, -1));

        step('0, 1'b0, 1'b0, -1, 1'b1);
        step('0, 1'b0, 1'b0, -1, 1'b1);
        foreach (tab[i]) step(tab[i].req, tab[i].gate, tab[i].hw, tab[i].exp, 1'b0);

        // Single requester, word halves: mem_data[17:9]=0x052, mem_data[8:0]=0x1C3.
        step('0, 1'b0, 1'b0, -1, 1'b1);
        a_tab[5] = 10'd17; s_tab[5] = 10'd3; h_tab[5] = 1'b0;
        step(bits(5, -1), 1'b1, 1'b0, 5, 1'b0);
        chk("r036_addr", 64'(mem_addr), 64'd17);
        chk("r036_sel", 64'(which_mem), 64'd3);
        for (int i = 0; i < 3; i++) step('0, 1'b1, 1'b0, -1, 1'b0);
        chk("r036_hi", 64'({rsp_val, rsp_id, rsp_data}), 64'({1'b1, 6'd5, 9'h052}));
        step('0, 1'b1, 1'b0, -1, 1'b0);
        h_tab[5] = 1'b1;
        step(bits(5, -1), 1'b1, 1'b0, 5, 1'b0);
        step(bits(5, -1), 1'b1, 1'b0, 5, 1'b0);
        step('0, 1'b1, 1'b0, -1, 1'b0);
        step('0, 1'b1, 1'b0, -1, 1'b0);
        chk("r036_lo", 64'({rsp_val, rsp_id, rsp_data}), 64'({1'b1, 6'd5, 9'h1C3}));
        for (int i = 0; i < 3; i++) step('0, 1'b1, 1'b0, -1, 1'b0);

        // Three grants then gate low: drain in order, busy drops after last rsp.
        step('0, 1'b0, 1'b0, -1, 1'b1);
        step(ones, 1'b1, 1'b0, 0, 1'b0);
        step(ones, 1'b1, 1'b0, 1, 1'b0);
        step(ones, 1'b1, 1'b0, 2, 1'b0);
        for (int i = 0; i < 6; i++) step(ones, 1'b0, 1'b0, -1, 1'b0);
        chk("r039_idle", 64'({busy, rsp_val}), 64'(0));

        // Reset one cycle after a grant: that read never responds.
        step(bits(4, -1), 1'b1, 1'b0, 4, 1'b0);
        step(bits(4, -1), 1'b1, 1'b0, -1, 1'b1);
        step(bits(9, 6), 1'b1, 1'b0, 6, 1'b0);
        for (int i = 0; i < 5; i++) step('0, 1'b1, 1'b0, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
